gcd_serial_if: RTL and testbench
================================

GCD_SERIAL_IF -- requirements
Module: gcd_serial_if

Interface
REQ-001 Parameter W, default 16: operand and result width in bits; W SHALL be a multiple of D, and W >= D.
REQ-002 Parameter D, default 4: digit width in bits carried per transfer on each serial bus.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 in_dig  input  D  operand digit.
REQ-006 in_val  input  1  in_dig is valid this cycle.
REQ-007 in_rdy  output  1  block accepts a digit this cycle.
REQ-008 out_dig  output  D  result digit.
REQ-009 out_val  output  1  out_dig is valid this cycle.
REQ-010 out_rdy  input  1  receiver accepts out_dig this cycle.
REQ-011 busy  output  1  high while in the CALC state.

Function
REQ-012 N = W/D. An input transfer SHALL occur when in_val && in_rdy at a clock edge; an output transfer SHALL occur when out_val && out_rdy at a clock edge.
REQ-013 The FSM SHALL have exactly three states: LOAD, CALC and SEND.
REQ-014 LOAD behaviour:
- in_rdy=1, out_val=0, busy=0.
- The SHALL accept exactly 2N digits.
- The first N digits form operand A, most-significant digit first.
- The next N digits form operand B, most-significant digit first.
REQ-015 When the 2N-th input transfer occurs, the FSM SHALL enter CALC on the same edge.
REQ-016 in_val low in LOAD SHALL hold the digit count and the partial operands unchanged; there is no input timeout.
REQ-017 CALC SHALL perform one step per cycle on registers A and B, all arithmetic unsigned and W bits wide:
- If A < B: swap A and B.
- Else if B != 0: A <= A - B.
- Else (B == 0): load the result register from A and enter SEND.
REQ-018 Zero operands:
- gcd(0,x) SHALL yield x.
- gcd(x,0) SHALL yield x.
- gcd(0,0) SHALL yield 0.
- No error flag is raised in any of these cases.
REQ-019 In CALC, in_rdy=0 and out_val=0; digits presented on in_dig SHALL be ignored.
REQ-020 SEND SHALL present N result digits, most-significant first, with out_val=1.
REQ-021 out_dig SHALL stay stable while out_val && !out_rdy, and SHALL advance by one digit per output transfer.
REQ-022 After the N-th output transfer, the FSM SHALL return to LOAD on the same edge: digit count cleared, in_rdy=1 on the next cycle.
REQ-023 The input and output handshakes SHALL never be active in the same cycle (in_rdy && out_val == 0 always).
REQ-024 Digit counters SHALL be sized to clog2(2N+1) bits and SHALL never wrap within a transaction.

Reset
REQ-025 On any clock edge with reset_n=0, in any state, the block SHALL:
- enter LOAD;
- clear A, B, the result register and the digit counter;
- drive in_rdy=1, out_val=0, out_dig=0, busy=0 from the following cycle.
REQ-026 A reset asserted mid-LOAD, mid-CALC or mid-SEND SHALL discard the transaction; no partial result SHALL be emitted afterwards.
REQ-027 Input transfers coincident with reset_n=0 SHALL be ignored.

Verification
REQ-028 W=16, D=4, in_val and out_rdy held high:
- Stimulus: digits 0,0,3,0 then 0,0,1,2 (48, 18).
- Response: busy for 9 cycles, then out_dig 0,0,0,6 on consecutive cycles, then in_rdy=1.
REQ-029 Zero operands:
- Operands 0 and 0x0005 -> result 0x0005.
- Operands 0x0007 and 0 -> result 0x0007.
- Operands 0 and 0 -> result 0x0000.
REQ-030 Backpressure:
- Stimulus: gcd(0xFFFF, 0x0003) with out_rdy toggling 1,0,0,1,...
- Response: result 0x0003; each digit held stable while out_rdy=0; exactly 4 output transfers.
REQ-031 Input gaps: in_val driven with random gaps during LOAD for gcd(0x1234, 0x0246) -> result 0x0002; no digit lost or duplicated.
REQ-032 Reset mid-operation:
- Pull reset_n low for 1 cycle during CALC, and separately after the 2nd output digit.
- Response: next cycle in_rdy=1, out_val=0, busy=0.
- A following gcd(21, 14) SHALL return 7.
REQ-033 W=8, D=2: gcd(0xC0, 0x48) = 0x18, delivered as digits 0,1,2,0.

Source files
------------

// File: rtl/gcd_serial_if_if.sv
// rtl/gcd_serial_if_if.sv - digit-serial operand/result bus for the GCD engine
interface gcd_serial_if_if #(
  parameter int D = 4
);
  logic [D-1:0] in_dig;
  logic         in_val;
  logic         in_rdy;
  logic [D-1:0] out_dig;
  logic         out_val;
  logic         out_rdy;
  logic         busy;

  modport master (
    output in_dig,
    output in_val,
    output out_rdy,
    input  in_rdy,
    input  out_dig,
    input  out_val,
    input  busy
  );

  modport slave (
    input  in_dig,
    input  in_val,
    input  out_rdy,
    output in_rdy,
    output out_dig,
    output out_val,
    output busy
  );
endinterface

// File: rtl/gcd_serial_if.sv
// rtl/gcd_serial_if.sv - subtractive GCD with digit-serial operand load and result drain
module gcd_serial_if #(
  parameter int W = 16,
  parameter int D = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  gcd_serial_if_if.slave bus
);
  localparam int N  = W / D;
  localparam int CW = $clog2(2 * N + 1);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_N    = CW'(N);
  localparam logic [CW-1:0] LAST_IN  = CW'(2 * N - 1);
  localparam logic [CW-1:0] LAST_OUT = CW'(N - 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          in_rdy;
  logic          out_val;
  logic          busy;
  logic [D-1:0]  out_dig;
  logic          in_xfer;
  logic          out_xfer;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= LOAD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_xfer  = bus.in_val && in_rdy;
  assign out_xfer = out_val && bus.out_rdy;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      LOAD: begin
        if (in_xfer) begin
          // First N digits build A, the next N build B, MSD first.
          if (cnt_q < CNT_N) begin
            a_d = (a_q << D) | W'(bus.in_dig);
          end else begin
            b_d = (b_q << D) | W'(bus.in_dig);
          end
          if (cnt_q == LAST_IN) begin
            cnt_d   = '0;
            state_d = CALC;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      CALC: begin
        if (a_q < b_q) begin
          a_d = b_q;
          b_d = a_q;
        end else if (b_q != '0) begin
          a_d = a_q - b_q;
        end else begin
          res_d   = a_q;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_xfer) begin
          // Shifting left keeps the next digit in the top slot; drained result ends at zero.
          res_d = res_q << D;
          if (cnt_q == LAST_OUT) begin
            cnt_d   = '0;
            state_d = LOAD;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    in_rdy  = (state_q == LOAD);
    out_val = (state_q == SEND);
    busy    = (state_q == CALC);
    out_dig = res_q[W-1 -: D];
  end

  assign bus.in_rdy  = in_rdy;
  assign bus.out_val = out_val;
  assign bus.busy    = busy;
  assign bus.out_dig = out_dig;
endmodule

// File: tb/tb_gcd_serial_if.sv
// tb/tb_gcd_serial_if.sv - randomized directed bench for gcd_serial_if with a Euclid reference
module tb_gcd_serial_if;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst16_n;
    logic rst8_n;

    gcd_serial_if_if #(.D(4)) bus16 ();
    gcd_serial_if_if #(.D(2)) bus8 ();

    gcd_serial_if #(.W(16), .D(4)) dut16 (.clk(clk), .reset_n(rst16_n), .bus(bus16));
    gcd_serial_if #(.W(8),  .D(2)) dut8  (.clk(clk), .reset_n(rst8_n),  .bus(bus8));

    int checks   = 0;
    int failures = 0;

    logic [15:0] r_res;
    int          r_busy;
    int          r_xfers;
    int          r_send_cyc;
    bit          r_stable;
    bit          r_excl;
    bit          r_timeout;
    logic        r_post_rdy;
    logic        r_post_val;

    task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x = a;
        logic [15:0] y = b;
        logic [15:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input bit gaps);
        logic [31:0] ops = {a, b};
        int i = 0;
        int guard = 0;
        while (i < 8 && guard < 400) begin
            @(negedge clk);
            guard++;
            bus16.in_val = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus16.in_dig = bus16.in_val ? ops[31 - 4 * i -: 4] : 4'($urandom);
            if (bus16.in_val && bus16.in_rdy) i++;
        end
        chk("send_digits", i === 8, i, 8);
    endtask

    task automatic recv16(input bit bp, input int stop_after);
        int k = 0;
        int guard = 0;
        int p = 0;
        bit holding = 0;
        logic [3:0] held = '0;
        r_res = '0; r_busy = 0; r_send_cyc = 0; r_stable = 1; r_excl = 1;
        while (k < stop_after && guard < 30000) begin
            @(negedge clk);
            guard++;
            bus16.in_dig = 4'($urandom);
            if (bus16.busy) r_busy++;
            if (bus16.in_rdy && bus16.out_val) r_excl = 0;
            if (bus16.out_val) begin
                r_send_cyc++;
                if (holding && bus16.out_dig !== held) r_stable = 0;
                bus16.out_rdy = bp ? ((p % 4 == 0) || (p % 4 == 3)) : 1'b1;
                p++;
                if (bus16.out_rdy) begin
                    r_res = {r_res[11:0], bus16.out_dig};
                    k++;
                    holding = 0;
                end else begin
                    holding = 1;
                    held = bus16.out_dig;
                end
            end else begin
                bus16.out_rdy = 1'b1;
            end
        end
        r_xfers = k;
        r_timeout = (k < stop_after);
        bus16.in_val = 1'b0;
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input bit gaps, input bit bp);
        send16(a, b, gaps);
        recv16(bp, 4);
        bus16.out_rdy = 1'b1;
        @(negedge clk);
        r_post_rdy = bus16.in_rdy;
        r_post_val = bus16.out_val;
    endtask

    task automatic check_txn(input string name, input logic [15:0] exp);
        chk(name, r_res === exp, r_res, exp);
        chk("no_timeout", r_timeout === 1'b0, r_timeout, 0);
        chk("handshake_exclusive", r_excl === 1'b1, r_excl, 1);
        chk("post_in_rdy", r_post_rdy === 1'b1, r_post_rdy, 1);
        chk("post_out_val", r_post_val === 1'b0, r_post_val, 0);
    endtask

    task automatic check_idle(input string name);
        logic [6:0] obs;
        obs = {bus16.in_rdy, bus16.out_val, bus16.busy, bus16.out_dig};
        chk(name, obs === 7'b1000000, obs, 7'b1000000);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb, exp;
        logic [15:0] ops8;
        logic [7:0]  res8;
        int i, guard;

        bus16.in_val = 1'b0; bus16.in_dig = '0; bus16.out_rdy = 1'b1;
        bus8.in_val  = 1'b0; bus8.in_dig  = '0; bus8.out_rdy  = 1'b1;
        rst16_n = 1'b0; rst8_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_in_rdy",  bus16.in_rdy === 1'b1,  bus16.in_rdy,  1);
        chk("reset_out_val", bus16.out_val === 1'b0, bus16.out_val, 0);
        chk("reset_busy",    bus16.busy === 1'b0,    bus16.busy,    0);
        chk("reset_out_dig", bus16.out_dig === 4'h0, bus16.out_dig, 0);
        rst16_n = 1'b1; rst8_n = 1'b1;

        run16(16'd48, 16'd18, 1'b0, 1'b0);
        check_txn("gcd_48_18", 16'h0006);
        chk("busy_cycles_48_18", r_busy === 9, r_busy, 9);
        chk("send_cycles_48_18", r_send_cyc === 4, r_send_cyc, 4);

        run16(16'h0000, 16'h0005, 1'b0, 1'b0);
        check_txn("gcd_0_5", 16'h0005);
        run16(16'h0007, 16'h0000, 1'b0, 1'b0);
        check_txn("gcd_7_0", 16'h0007);
        run16(16'h0000, 16'h0000, 1'b0, 1'b0);
        check_txn("gcd_0_0", 16'h0000);

        run16(16'hFFFF, 16'h0003, 1'b0, 1'b1);
        check_txn("gcd_ffff_3_bp", 16'h0003);
        chk("bp_digit_stable", r_stable === 1'b1, r_stable, 1);
        chk("bp_xfers", r_xfers === 4, r_xfers, 4);
        chk("bp_send_cycles", r_send_cyc === 8, r_send_cyc, 8);

        run16(16'h1234, 16'h0246, 1'b1, 1'b0);
        check_txn("gcd_1234_0246_gaps", 16'h0002);

        for (int n = 0; n < 6; n++) begin
            ra = 16'($urandom_range(0, 4095));
            rb = 16'($urandom_range(1, 4095));
            exp = ref_gcd(ra, rb);
            run16(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check_txn("gcd_random", exp);
            chk("random_digit_stable", r_stable === 1'b1, r_stable, 1);
        end

        send16(16'd48, 16'd18, 1'b0);
        repeat (3) @(negedge clk);
        chk("calc_busy_before_reset", bus16.busy === 1'b1, bus16.busy, 1);
        bus16.in_val = 1'b0;
        rst16_n = 1'b0;
        @(negedge clk);
        rst16_n = 1'b1;
        check_idle("idle_after_calc_reset");
        run16(16'd21, 16'd14, 1'b0, 1'b0);
        check_txn("gcd_21_14_after_calc_reset", 16'h0007);

        send16(16'd48, 16'd18, 1'b0);
        recv16(1'b0, 2);
        chk("partial_digits", r_res === 16'h0000, r_res, 0);
        @(negedge clk);
        rst16_n = 1'b0;
        @(negedge clk);
        rst16_n = 1'b1;
        check_idle("idle_after_send_reset");
        run16(16'd21, 16'd14, 1'b0, 1'b0);
        check_txn("gcd_21_14_after_send_reset", 16'h0007);

        ops8 = {8'hC0, 8'h48};
        i = 0; guard = 0;
        while (i < 8 && guard < 100) begin
            @(negedge clk);
            guard++;
            bus8.in_val = 1'b1;
            bus8.in_dig = ops8[15 - 2 * i -: 2];
            if (bus8.in_rdy) i++;
        end
        i = 0; guard = 0; res8 = '0;
        while (i < 4 && guard < 1000) begin
            @(negedge clk);
            guard++;
            bus8.in_dig = 2'($urandom);
            if (bus8.out_val) begin
                res8 = {res8[5:0], bus8.out_dig};
                i++;
            end
        end
        bus8.in_val = 1'b0;
        chk("w8_xfers", i === 4, i, 4);
        chk("w8_gcd_c0_48", res8 === 8'h18, res8, 8'h18);
        @(negedge clk);
        chk("w8_post_in_rdy", bus8.in_rdy === 1'b1, bus8.in_rdy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
